// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch and datapath-control bundle for cpu_sequencer.
// The slave modport is the sequencer side; the master modport is fetch/datapath.
interface cpu_sequencer_if #(
  parameter int unsigned NUM_REGS = 4
);
  logic                instr_valid;
  logic [7:0]          instr;
  logic                instr_ready;
  logic                resume;
  logic [3:0]          alu_op;
  logic [1:0]          sel_a;
  logic [1:0]          sel_b;
  logic [NUM_REGS-1:0] reg_save;
  logic [NUM_REGS-1:0] reg_clear;
  logic                busy;
  logic                halted;
  logic                illegal;
  logic [7:0]          instr_count;

  modport master (
    output instr_valid, instr, resume,
    input  instr_ready, alu_op, sel_a, sel_b, reg_save, reg_clear,
           busy, halted, illegal, instr_count
  );

  modport slave (
    input  instr_valid, instr, resume,
    output instr_ready, alu_op, sel_a, sel_b, reg_save, reg_clear,
           busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction, drives ALU selects
// through DECODE/EXECUTE/WRITEBACK and issues a single save/clear strobe.
module cpu_sequencer #(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_instr;
  logic [7:0]          r_count;
  logic                r_illegal;

  logic [3:0]          w_op;
  logic [1:0]          w_dst;
  logic [1:0]          w_src;
  logic [NUM_REGS-1:0] w_dst_onehot;

  logic                w_accept;
  logic                w_retire;
  logic                w_set_illegal;
  logic                w_instr_ready;
  logic                w_busy;
  logic                w_halted;
  logic [3:0]          w_alu_op;
  logic [1:0]          w_sel_a;
  logic [1:0]          w_sel_b;
  logic [NUM_REGS-1:0] w_reg_save;
  logic [NUM_REGS-1:0] w_reg_clear;

  assign w_op  = r_instr[7:4];
  assign w_dst = r_instr[3:2];
  assign w_src = r_instr[1:0];

  always_comb begin
    w_dst_onehot        = '0;
    w_dst_onehot[w_dst] = 1'b1;
  end

  // Strobes and selects decode straight from the state register so an
  // asynchronous reset removes them in the same instant.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_instr_ready = 1'b0;
    w_busy        = 1'b0;
    w_halted      = 1'b0;
    w_alu_op      = '0;
    w_sel_a       = '0;
    w_sel_b       = '0;
    w_reg_save    = '0;
    w_reg_clear   = '0;

    case (r_state)
      S_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        w_busy   = 1'b1;
        w_alu_op = w_op;
        w_sel_a  = w_dst;
        w_sel_b  = w_src;
        if (w_op == 4'hF) begin
          w_retire     = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        w_busy       = 1'b1;
        w_alu_op     = w_op;
        w_sel_a      = w_dst;
        w_sel_b      = w_src;
        w_state_next = S_WRITEBACK;
      end

      S_WRITEBACK: begin
        w_busy       = 1'b1;
        w_alu_op     = w_op;
        w_sel_a      = w_dst;
        w_sel_b      = w_src;
        w_retire     = 1'b1;
        w_state_next = S_IDLE;
        if (w_op inside {[4'h1:4'h7]}) begin
          w_reg_save = w_dst_onehot;
        end else if (w_op == 4'h8) begin
          w_reg_clear = w_dst_onehot;
        end else if (w_op inside {[4'h9:4'hE]}) begin
          w_set_illegal = 1'b1;
        end
      end

      S_HALT: begin
        w_halted = 1'b1;
        if (bus.resume) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_instr <= bus.instr;
      end
      if (w_retire) begin
        r_count <= r_count + 8'd1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign bus.instr_ready = w_instr_ready;
  assign bus.busy        = w_busy;
  assign bus.halted      = w_halted;
  assign bus.alu_op      = w_alu_op;
  assign bus.sel_a       = w_sel_a;
  assign bus.sel_b       = w_sel_b;
  assign bus.reg_save    = w_reg_save;
  assign bus.reg_clear   = w_reg_clear;
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes expected per-instruction
// results; a negedge monitor collects each busy window and compares.
module tb_cpu_sequencer;

  logic clk;
  logic reset_n;

  cpu_sequencer_if #(.NUM_REGS(4)) bus ();

  cpu_sequencer #(.NUM_REGS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  save;
    logic [3:0]  clear;
    logic [3:0]  alu;
    logic [1:0]  sa;
    logic [1:0]  sb;
    int unsigned cycles;
    logic [7:0]  cnt;
    logic        ill;
    logic        hlt;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_ill = 1'b0;
  bit          mon_en = 1'b0;
  bit          in_win = 1'b0;
  time         last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] ins, input bit hold, input bit chk_gap);
    exp_t e;
    logic [3:0] op;
    bit ok;
    op       = ins[7:4];
    e.alu    = op;
    e.sa     = ins[3:2];
    e.sb     = ins[1:0];
    e.save   = 4'b0000;
    e.clear  = 4'b0000;
    e.hlt    = (op == 4'hF);
    e.cycles = (op == 4'hF) ? 1 : 3;
    if (op >= 4'h1 && op <= 4'h7) e.save = 4'b0001 << ins[3:2];
    if (op == 4'h8) e.clear = 4'b0001 << ins[3:2];
    if (op >= 4'h9 && op <= 4'hE) exp_ill = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    e.cnt   = exp_cnt;
    e.ill   = exp_ill;
    sb_q.push_back(e);

    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    @(posedge clk);
    if (chk_gap) check("accept_gap_cycles", 32'(($time - last_acc) / 10), 32'd4);
    last_acc = $time;
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 30; n++) begin
      if (sb_q.size() == 0 && !in_win) break;
      @(negedge clk);
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: per busy window record timing, strobes and select stability.
  initial begin
    int unsigned win_cyc, strobe_n, strobe_cyc;
    logic [3:0]  seen_save, seen_clear, alu0;
    logic [1:0]  sa0, sb0;
    bit          unstable;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_win = 1'b0;
      end else if (bus.busy) begin
        if (!in_win) begin
          in_win     = 1'b1;
          win_cyc    = 0;
          strobe_n   = 0;
          strobe_cyc = 0;
          seen_save  = 4'b0000;
          seen_clear = 4'b0000;
          alu0       = bus.alu_op;
          sa0        = bus.sel_a;
          sb0        = bus.sel_b;
          unstable   = 1'b0;
        end
        win_cyc++;
        if (bus.reg_save != 4'b0000 || bus.reg_clear != 4'b0000) begin
          strobe_n++;
          strobe_cyc = win_cyc;
        end
        seen_save  = seen_save | bus.reg_save;
        seen_clear = seen_clear | bus.reg_clear;
        if (bus.alu_op != alu0 || bus.sel_a != sa0 || bus.sel_b != sb0) unstable = 1'b1;
      end else begin
        check("idle_outputs_zero",
              {20'd0, bus.alu_op, bus.sel_a, bus.sel_b, bus.reg_save, bus.reg_clear}, 32'd0);
        if (in_win) begin
          in_win = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected_instruction", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("busy_cycles", win_cyc, e.cycles);
            check("alu_op", {28'd0, alu0}, {28'd0, e.alu});
            check("sel_a", {30'd0, sa0}, {30'd0, e.sa});
            check("sel_b", {30'd0, sb0}, {30'd0, e.sb});
            check("selects_stable", {31'd0, unstable}, 32'd0);
            check("reg_save", {28'd0, seen_save}, {28'd0, e.save});
            check("reg_clear", {28'd0, seen_clear}, {28'd0, e.clear});
            check("strobe_count", strobe_n, (e.save != 0 || e.clear != 0) ? 1 : 0);
            check("strobe_cycle", strobe_cyc, (e.save != 0 || e.clear != 0) ? 3 : 0);
            check("instr_count", {24'd0, bus.instr_count}, {24'd0, e.cnt});
            check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
            check("halted", {31'd0, bus.halted}, {31'd0, e.hlt});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n         = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.resume      = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_outputs_zero",
          {bus.busy, bus.halted, bus.illegal, bus.alu_op, bus.sel_a, bus.sel_b,
           bus.reg_save, bus.reg_clear}, 32'd0);
    check("rst_instr_count", {24'd0, bus.instr_count}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    send(8'h36, 1'b0, 1'b0);
    drain();

    // Back-to-back with valid held high: CLR dst 3, then NOP.
    send(8'h8C, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    drain();

    send(8'hA0, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    drain();

    // resume has no effect outside HALT.
    bus.resume = 1'b1;
    @(negedge clk);
    bus.resume = 1'b0;
    check("resume_ignored_idle", {30'd0, bus.instr_ready, bus.busy}, 32'd2);

    send(8'hF0, 1'b0, 1'b0);
    drain();
    bus.instr       = 8'h12;
    bus.instr_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("halt_holds", {29'd0, bus.halted, bus.instr_ready, bus.busy}, 32'd4);
    end
    bus.resume = 1'b1;
    @(negedge clk);
    bus.resume = 1'b0;
    check("resume_to_idle", {30'd0, bus.halted, bus.instr_ready}, 32'd1);
    send(8'h12, 1'b0, 1'b0);
    drain();

    // Reset during WRITEBACK of 0x25.
    mon_en          = 1'b0;
    bus.instr       = 8'h25;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wb_save_before_reset", {28'd0, bus.reg_save}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("reset_truncates_save", {28'd0, bus.reg_save}, 32'd0);
    check("reset_to_idle", {30'd0, bus.instr_ready, bus.busy}, 32'd2);
    check("reset_clears_state", {23'd0, bus.illegal, bus.instr_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 8'd0;
    exp_ill = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 256; i++) begin
      send(8'h00, 1'b0, 1'b0);
    end
    drain();
    check("count_wrapped", {24'd0, bus.instr_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
